// File: rtl/frame_stimulus_driver_pkg.sv
// Shared definitions for the frame stimulus driver and any future monitor
// of the 8-state frame state machine. Phase encoding matches the target's.
package frame_stimulus_driver_pkg;

  localparam logic [2:0] S0 = 3'h0;
  localparam logic [2:0] S1 = 3'h1;
  localparam logic [2:0] S2 = 3'h2;
  localparam logic [2:0] S3 = 3'h3;
  localparam logic [2:0] S4 = 3'h4;
  localparam logic [2:0] S5 = 3'h5;
  localparam logic [2:0] S6 = 3'h6;
  localparam logic [2:0] S7 = 3'h7;

  localparam logic [2:0] IDLE_CODE_DEF = 3'b000;

  // Expected {outp@phase2, outp@phase3} for a frame driven with code c.
  function automatic logic [1:0] exp_outp(input logic [2:0] code);
    exp_outp = {code[2] & (code[0] | code[1]), code[0] | code[1]};
  endfunction

endpackage

// File: rtl/frame_stimulus_driver_phase_tracker.sv
// Mirrors the target's state sequence so the driver knows where each frame
// begins and ends. long_sel is the target's b[2] as currently driven.
//
// state | meaning
// S0    | first cycle of a frame (new code visible to the target)
// S1    | second cycle
// S2    | first informative outp sample
// S3    | second informative outp sample; short frames end here
// S4-S6 | long-frame extension
// S7    | last cycle of a long frame
module phase_tracker
  import frame_stimulus_driver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       long_sel,
  output logic [2:0] ph,
  output logic       frame_end
);

  logic [2:0] ph_next;

  // Next phase: linear count, except a short frame returns to S0 after S3.
  always_comb begin
    ph_next = ph + 3'd1;
    if (ph == S3 && !long_sel) ph_next = S0;
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) ph <= S0;
    else     ph <= ph_next;
  end

  assign frame_end = (ph == S7) | ((ph == S3) & ~long_sel);

endmodule

// File: rtl/frame_stimulus_driver.sv
// Transmit-side driver for the frame state machine: loads one command code
// per frame at frame boundaries, captures the two informative outp samples
// and reports a per-frame response with mismatch counting.
module frame_stimulus_driver
  import frame_stimulus_driver_pkg::*;
#(
  parameter logic [2:0] IDLE_CODE = IDLE_CODE_DEF,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_code,
  output logic             cmd_ready,
  output logic [2:0]       b_out,
  input  logic             outp_in,
  output logic             rsp_valid,
  output logic [1:0]       rsp_samp,
  output logic             rsp_long,
  output logic             rsp_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0] ph;
  logic       frame_end;
  logic       busy;
  logic       s2;
  logic [1:0] samp;
  logic       mismatch;

  phase_tracker u_phase (
    .clk       (clk),
    .rst       (rst),
    .long_sel  (b_out[1]),
    .ph        (ph),
    .frame_end (frame_end)
  );

  assign cmd_ready = frame_end;
  assign samp      = {s2, outp_in};
  assign mismatch  = (samp != exp_outp(b_out));

  // Frame loader: code, busy flag and frame count change only at frame_end.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_out     <= IDLE_CODE;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else if (frame_end) begin
      if (cmd_valid) begin
        b_out     <= cmd_code;
        busy      <= 1'b1;
        frame_cnt <= frame_cnt + CNT_ONE;
      end else begin
        b_out <= IDLE_CODE;
        busy  <= 1'b0;
      end
    end
  end

  // Sample capture and response generation; idle frames never respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_samp  <= 2'b00;
      rsp_long  <= 1'b0;
      rsp_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (ph == S2) s2 <= outp_in;
      if (ph == S3 && busy) begin
        rsp_valid <= 1'b1;
        rsp_samp  <= samp;
        rsp_long  <= b_out[1];
        rsp_err   <= mismatch;
        if (mismatch && err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_frame_stimulus_driver.sv
// Scoreboard bench for frame_stimulus_driver. The reference model tracks
// frames by position and length; responses are queued with their expected
// cycle and popped by an independent monitor.
module tb_frame_stimulus_driver;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic [2:0]       cmd_code;
  logic             cmd_ready;
  logic [2:0]       b_out;
  logic             outp_in;
  logic             rsp_valid;
  logic [1:0]       rsp_samp;
  logic             rsp_long;
  logic             rsp_err;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  frame_stimulus_driver #(.IDLE_CODE(3'b000), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_ready (cmd_ready),
    .b_out     (b_out),
    .outp_in   (outp_in),
    .rsp_valid (rsp_valid),
    .rsp_samp  (rsp_samp),
    .rsp_long  (rsp_long),
    .rsp_err   (rsp_err),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] samp;
    logic       lng;
    logic       err;
  } rsp_t;

  rsp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model state (describes the cycle currently in progress)
  int               m_pos;
  int               m_len;
  logic [2:0]       m_code;
  logic             m_busy;
  logic             m_s2;
  logic [CNT_W-1:0] m_fcnt;
  logic [CNT_W-1:0] m_ecnt;
  logic [1:0]       m_samp;
  logic             m_long;
  logic             m_err;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endfunction

  function automatic logic [1:0] model_exp(input logic [2:0] c);
    logic any01;
    any01 = c[0] | c[1];
    return {c[2] & any01, any01};
  endfunction

  function automatic void model_reset();
    m_pos  = 0;
    m_len  = 4;
    m_code = 3'b000;
    m_busy = 1'b0;
    m_s2   = 1'b0;
    m_fcnt = '0;
    m_ecnt = '0;
    m_samp = 2'b00;
    m_long = 1'b0;
    m_err  = 1'b0;
  endfunction

  // One clock cycle: check DUT state against model, drive inputs, advance model.
  // mode 0: target cooperates at phases 2/3; 1: outp forced 0; 2: outp random.
  task automatic step(input logic v, input logic [2:0] c, input int mode, input logic r);
    logic       o;
    logic [1:0] e;
    logic [1:0] smp;
    logic       er;
    chk("b_out",     32'(b_out),     32'(m_code));
    chk("cmd_ready", 32'(cmd_ready), 32'(m_pos == m_len - 1));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    chk("err_cnt",   32'(err_cnt),   32'(m_ecnt));
    chk("rsp_hold",  32'({rsp_samp, rsp_long, rsp_err}), 32'({m_samp, m_long, m_err}));

    e = model_exp(m_code);
    case (mode)
      1:       o = 1'b0;
      2:       o = 1'($urandom_range(0, 1));
      default: o = (m_pos == 2) ? e[1] : (m_pos == 3) ? e[0] : 1'($urandom_range(0, 1));
    endcase
    rst       = r;
    cmd_valid = v;
    cmd_code  = c;
    outp_in   = o;

    if (r) begin
      model_reset();
    end else begin
      if (m_pos == 3 && m_busy) begin
        smp = {m_s2, o};
        er  = (smp != e);
        if (er && m_ecnt != {CNT_W{1'b1}}) m_ecnt = m_ecnt + 1'b1;
        sbq.push_back('{cyc: cyc + 1, samp: smp, lng: m_code[1], err: er});
        m_samp = smp;
        m_long = m_code[1];
        m_err  = er;
      end
      if (m_pos == 2) m_s2 = o;
      if (m_pos == m_len - 1) begin
        if (v) begin
          m_code = c;
          m_busy = 1'b1;
          m_fcnt = m_fcnt + 1'b1;
        end else begin
          m_code = 3'b000;
          m_busy = 1'b0;
        end
        m_pos = 0;
        m_len = m_code[1] ? 8 : 4;
      end else begin
        m_pos++;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_idle(input int n, input int mode);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, mode, 1'b0);
  endtask

  // Wait (idle) for the next frame boundary, then offer a command there.
  task automatic offer(input logic [2:0] c, input int mode);
    for (int i = 0; i < 8 && m_pos != m_len - 1; i++) step(1'b0, 3'b000, mode, 1'b0);
    step(1'b1, c, mode, 1'b0);
  endtask

  // Response monitor: pops the scoreboard whenever a response is due or seen.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rsp_valid && sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_missing cyc=%0d got rsp_valid=0 want 1 (due cyc %0d)", cyc, sbq[0].cyc);
        void'(sbq.pop_front());
      end else if (rsp_valid === 1'b1) begin
        if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected cyc=%0d got rsp_valid=1 want 0", cyc);
        end else begin
          e = sbq.pop_front();
          chk("rsp_samp", 32'(rsp_samp), 32'(e.samp));
          chk("rsp_long", 32'(rsp_long), 32'(e.lng));
          chk("rsp_err",  32'(rsp_err),  32'(e.err));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_code  = 3'b000;
    outp_in   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // idle frames after reset
    run_idle(12, 0);

    // long frame, matching samples
    offer(3'b111, 0);
    run_idle(8, 0);

    // short frame, then a command held valid across the next boundary
    offer(3'b001, 0);
    for (int i = 0; i < 8; i++) step(1'b1, 3'b001, 0, 1'b0);
    run_idle(6, 0);

    // mismatch frame, then drive err_cnt into saturation
    offer(3'b101, 1);
    run_idle(6, 0);
    for (int i = 0; i < 18; i++) offer(3'b101, 1);
    run_idle(8, 1);

    // reset in the middle of a command frame drops it
    offer(3'b111, 0);
    for (int i = 0; i < 8 && m_pos != 2; i++) step(1'b0, 3'b000, 0, 1'b0);
    step(1'b0, 3'b000, 0, 1'b1);
    run_idle(10, 0);

    // randomized traffic: codes and valid toggle freely mid-frame
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 2 : 0, $urandom_range(0, 149) == 0);

    run_idle(12, 0);
    @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_stimulus_driver.md
Name: frame_stimulus_driver

Overview:
Transmit-side partner of the 8-state frame state machine: drives its 3-bit `b[3:1]` input and samples its `outp`. It keeps a mirrored copy of the target's state sequence and loads one command code per frame, only at frame boundaries. It captures the two informative `outp` samples (phases 2 and 3), checks them against expected values and returns a per-frame response. It sits in the test/stimulus layer in front of the state machine; `rst` also drives the target's reset (target `rst_n = ~rst`).

Parameters:
IDLE_CODE, 3'b000, value driven on `b_out` in frames with no accepted command
CNT_W, 16, width of frame and error counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; synchronous, active-high; resets this block and (inverted) the target
cmd_valid  in  1  command code available
cmd_code  in  3  code for next frame; bit index 2:0 maps to target b[3:1]
cmd_ready  out  1  combinational; high only in the last cycle of a frame
b_out  out  3  registered drive to target b[3:1]
outp_in  in  1  target outp (combinational in target)
rsp_valid  out  1  one-cycle pulse, response for a command frame
rsp_samp  out  2  {outp@phase2, outp@phase3}
rsp_long  out  1  1 = frame was 8 cycles (code bit1 set)
rsp_err  out  1  samples differ from expected
frame_cnt  out  CNT_W  commands sent, wraps modulo 2^CNT_W
err_cnt  out  CNT_W  mismatching frames, saturates at all-ones

Behaviour:
- Reset (`rst` high at edge): ph=0, b_out=IDLE_CODE, busy=0, rsp_valid=0, rsp_samp=0, rsp_long=0, rsp_err=0, frame_cnt=0, err_cnt=0. An in-flight command is dropped and produces no response.
- Phase counter ph[2:0] mirrors target state, advancing every cycle:
  - 0→1→2→3.
  - 3→4 if b_out[1] (target b[2]); otherwise 3→0.
  - 4→5→6→7→0.
- frame_end = (ph==7) | (ph==3 & ~b_out[1]).
- Short frame = 4 cycles; long frame = 8 cycles.
- cmd_ready = frame_end, independent of cmd_valid.
- At a frame_end edge:
  - If cmd_valid: b_out<=cmd_code, busy<=1, frame_cnt++.
  - Else: b_out<=IDLE_CODE, busy<=0.
- b_out is constant for the whole frame.
- Latency: command accepted in cycle t → driven on b_out from t+1 (ph 0).
- Expected samples, with code c:
  - exp2 = c[2]&(c[0]|c[1])
  - exp3 = c[0]|c[1]
- Capture:
  - At the edge ending a ph==2 cycle, latch s2<=outp_in.
  - At the edge ending a ph==3 cycle, if busy:
    - rsp_valid<=1, rsp_samp<={s2,outp_in}, rsp_long<=b_out[1].
    - rsp_err<=({s2,outp_in}!={exp2,exp3}).
    - err_cnt++ (saturating) on mismatch.
- Response timing: rsp_valid is high in cycle t+5 only. There is no backpressure; rsp_* fields hold their values until the next pulse.
- Idle frames (busy=0): never pulse rsp_valid.
- Short back-to-back frames: the accept of frame N+1 (ph3 cycle) and the rsp_valid of frame N (next cycle) are independent and both happen.
- Mid-frame cmd_valid: ignored until frame_end; the code may change freely while ready is low.

Decomposition:
- Shared package:
  - Phase localparams S0..S7 (3'h0..3'h7), identical to the target's encoding.
  - Function exp_outp(code) → {exp2,exp3}.
  - IDLE_CODE default.
- Sub-module phase_tracker:
  - Inputs: clk, rst, long_sel.
  - Outputs: ph, frame_end.
  - Reusable by future monitors of the same target.

Test Plan:
1. Reset, then cmd_valid held low for 12 cycles → b_out=000; ph cycles 0,1,2,3,0…; cmd_ready high every 4th cycle (ph3); no rsp_valid; frame_cnt=0.
2. Code 3'b111 offered at the first ready → b_out=111 for 8 cycles; rsp_valid 5 cycles after accept with rsp_samp=2'b11, rsp_long=1, rsp_err=0; frame_cnt=1.
3. Code 3'b001 → 4-cycle frame; rsp_samp=2'b01, rsp_long=0; a second command, valid throughout, is accepted 4 cycles after the first.
4. Target outp forced to 0 during a 3'b101 frame → rsp_err=1, err_cnt=1. Preload err_cnt to all-ones and repeat → err_cnt stays all-ones.
5. `rst` asserted at ph==2 of a command frame → next cycle all outputs at reset values; no rsp_valid for the dropped frame.
6. cmd_valid toggling mid-frame with changing codes → only the code present at frame_end is loaded; b_out is stable across the frame.
